// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard for tracking outstanding producers.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rn,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wn,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                iss_v,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREGS-1:0]    busy_vec
);

  localparam bit ZR  = (ZERO_REG != 0);
  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] busy_next;

  genvar gi;

  // Per-register scoreboard update: a new issue outranks a same-cycle writeback.
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_sb
      logic hit;
      always_comb begin
        hit = 1'b0;
        for (int w = 0; w < NWR; w++) begin
          if (we[w] && (wn[w*AW +: AW] == AW'(gi))) hit = 1'b1;
        end
      end
      assign clr_vec[gi]   = hit;
      assign set_vec[gi]   = iss_v && (iss_rd == AW'(gi)) && !(ZR && (gi == 0));
      assign busy_next[gi] = set_vec[gi] ? 1'b1 : (clr_vec[gi] ? 1'b0 : busy[gi]);
    end
  endgenerate

  // Ascending port order makes the highest-index port win on address collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      busy <= busy_next;
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && !(ZR && (wn[w*AW +: AW] == '0))) begin
          regs[wn[w*AW +: AW]] <= wd[w*XLEN +: XLEN];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      assign addr = rn[gi*AW +: AW];
      always_comb begin
        data = regs[addr];
        if (BYP) begin
          for (int w = 0; w < NWR; w++) begin
            if (we[w] && (wn[w*AW +: AW] == addr)) data = wd[w*XLEN +: XLEN];
          end
        end
        // Reset must also mask bypassed write data that is still pending.
        if ((ZR && (addr == '0)) || rst) data = '0;
      end
      assign rd[gi*XLEN +: XLEN] = data;
      assign rbusy[gi] = busy[addr] & ~(BYP & clr_vec[addr]);
    end
  endgenerate

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus a random run checked against a
// reference model through an expected-result queue.
module tb_regfile_mp;
  localparam int XL  = 32;
  localparam int NR  = 32;
  localparam int AWL = 5;
  localparam int RDN = 4;
  localparam int WRN = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [RDN*AWL-1:0] rn;
  logic [RDN*XL-1:0]  rd, rd_nb;
  logic [RDN-1:0]     rbusy, rbusy_nb;
  logic [WRN-1:0]     we;
  logic [WRN*AWL-1:0] wn;
  logic [WRN*XL-1:0]  wd;
  logic               iss_v;
  logic [AWL-1:0]     iss_rd;
  logic [NR-1:0]      busy_vec, busy_nb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [RDN*XL-1:0] rd;
    logic [RDN-1:0]    rbusy;
    logic [NR-1:0]     busy;
  } exp_t;
  exp_t exp_q[$];

  logic [XL-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(RDN), .NWR(WRN), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rn(rn), .rd(rd), .rbusy(rbusy), .we(we), .wn(wn), .wd(wd),
    .iss_v(iss_v), .iss_rd(iss_rd), .busy_vec(busy_vec)
  );

  regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(RDN), .NWR(WRN), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rn(rn), .rd(rd_nb), .rbusy(rbusy_nb), .we(we), .wn(wn), .wd(wd),
    .iss_v(iss_v), .iss_rd(iss_rd), .busy_vec(busy_nb)
  );

  function automatic logic m_clr(input logic [AWL-1:0] a);
    for (int w = 0; w < WRN; w++) if (we[w] && wn[w*AWL +: AWL] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XL-1:0] m_read(input logic [AWL-1:0] a);
    if (a == 0) return '0;
    for (int w = WRN - 1; w >= 0; w--) if (we[w] && wn[w*AWL +: AWL] == a) return wd[w*XL +: XL];
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_busy = '0;
  endtask

  task automatic m_update();
    logic [NR-1:0] nb;
    if (rst) begin
      m_reset();
      return;
    end
    for (int r = 0; r < NR; r++) begin
      if (iss_v && iss_rd == AWL'(r) && r != 0) nb[r] = 1'b1;
      else if (m_clr(AWL'(r)))                  nb[r] = 1'b0;
      else                                      nb[r] = m_busy[r];
    end
    for (int w = 0; w < WRN; w++)
      if (we[w] && wn[w*AWL +: AWL] != 0) m_regs[wn[w*AWL +: AWL]] = wd[w*XL +: XL];
    m_busy = nb;
  endtask

  function automatic logic [AWL-1:0] rand_addr();
    return ($urandom_range(0, 1) == 1) ? AWL'($urandom_range(0, 7)) : AWL'($urandom_range(0, 31));
  endfunction

  task automatic idle();
    we = '0; wn = '0; wd = '0; iss_v = 1'b0; iss_rd = '0; rn = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    we = 2'b01; wn[4:0] = 5'd5; wd[31:0] = 32'h1111_2222; iss_v = 1'b1; iss_rd = 5'd4;
    rn[4:0] = 5'd5;
    @(posedge clk); @(negedge clk);
    checks++; if (rd !== '0) begin errors++; $display("FAIL reset_rd: got %h expected 0", rd); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
    rst = 1'b0; idle(); rn[4:0] = 5'd5;
    @(posedge clk); @(negedge clk);
    checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL reset_release_rd: got %h expected 0", rd[31:0]); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_release_busy: got %h expected 0", busy_vec); end
    // Mid-operation: state must clear without a clock edge.
    we = 2'b01; wn[4:0] = 5'd5; wd[31:0] = 32'h55; iss_v = 1'b1; iss_rd = 5'd6;
    @(posedge clk); @(negedge clk);
    idle(); rn[4:0] = 5'd5; #1;
    checks++; if (rd[31:0] !== 32'h55 || busy_vec !== 32'h40) begin
      errors++; $display("FAIL midop_pre: got rd=%h busy=%h expected rd=55 busy=40", rd[31:0], busy_vec);
    end
    rst = 1'b1; #1;
    checks++; if (rd[31:0] !== 32'h0 || busy_vec !== '0) begin
      errors++; $display("FAIL async_reset: got rd=%h busy=%h expected 0", rd[31:0], busy_vec);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write_read();
    idle(); we = 2'b01; wn[4:0] = 5'd5; wd[31:0] = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    idle(); rn[4:0] = 5'd5; rn[9:5] = 5'd0; #1;
    checks++; if (rd[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd0: got %h expected deadbeef", rd[31:0]); end
    checks++; if (rd[63:32] !== 32'h0) begin errors++; $display("FAIL wr_rd1_r0: got %h expected 0", rd[63:32]); end
    checks++; if (rd_nb[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd0_nobyp: got %h expected deadbeef", rd_nb[31:0]); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle(); we = 2'b01; wn[4:0] = 5'd7; wd[31:0] = 32'h1234; rn[4:0] = 5'd7; #1;
    checks++; if (rd[31:0] !== 32'h1234) begin errors++; $display("FAIL bypass_same_cycle: got %h expected 1234", rd[31:0]); end
    checks++; if (rd_nb[31:0] !== 32'h0) begin errors++; $display("FAIL nobypass_old: got %h expected 0", rd_nb[31:0]); end
    @(posedge clk); @(negedge clk);
    idle(); rn[4:0] = 5'd7; #1;
    checks++; if (rd_nb[31:0] !== 32'h1234) begin errors++; $display("FAIL nobypass_after: got %h expected 1234", rd_nb[31:0]); end
  endtask

  task automatic test_zero_collision();
    @(negedge clk);
    idle(); we = 2'b01; wn[4:0] = 5'd0; wd[31:0] = 32'hFFFF_FFFF; rn[4:0] = 5'd0; #1;
    checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL zero_bypass: got %h expected 0", rd[31:0]); end
    @(posedge clk); @(negedge clk);
    idle(); rn[4:0] = 5'd0; #1;
    checks++; if (rd[31:0] !== 32'h0 || rd_nb[31:0] !== 32'h0) begin
      errors++; $display("FAIL zero_stored: got %h/%h expected 0", rd[31:0], rd_nb[31:0]);
    end
    we = 2'b11; wn = {5'd3, 5'd3}; wd = {32'hB, 32'hA}; rn[4:0] = 5'd3; #1;
    checks++; if (rd[31:0] !== 32'hB) begin errors++; $display("FAIL collide_bypass: got %h expected b", rd[31:0]); end
    @(posedge clk); @(negedge clk);
    idle(); rn[4:0] = 5'd3; #1;
    checks++; if (rd[31:0] !== 32'hB || rd_nb[31:0] !== 32'hB) begin
      errors++; $display("FAIL collide_stored: got %h/%h expected b", rd[31:0], rd_nb[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle(); iss_v = 1'b1; iss_rd = 5'd9; rn[4:0] = 5'd9; #1;
    checks++; if (busy_vec !== '0 || rbusy[0] !== 1'b0) begin
      errors++; $display("FAIL issue_same_cycle: got busy=%h rbusy=%b expected 0/0", busy_vec, rbusy[0]);
    end
    @(posedge clk); @(negedge clk);
    idle(); rn[4:0] = 5'd9; #1;
    checks++; if (busy_vec !== 32'h200 || rbusy[0] !== 1'b1) begin
      errors++; $display("FAIL issue_set: got busy=%h rbusy=%b expected 200/1", busy_vec, rbusy[0]);
    end
    we = 2'b01; wn[4:0] = 5'd9; wd[31:0] = 32'h99; #1;
    checks++; if (rbusy[0] !== 1'b0 || rbusy_nb[0] !== 1'b1) begin
      errors++; $display("FAIL wb_rbusy: got %b/%b expected 0/1", rbusy[0], rbusy_nb[0]);
    end
    @(posedge clk); @(negedge clk);
    idle(); #1;
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL wb_clear: got %h expected 0", busy_vec); end
    iss_v = 1'b1; iss_rd = 5'd9; we = 2'b10; wn[9:5] = 5'd9; wd[63:32] = 32'h77;
    @(posedge clk); @(negedge clk);
    idle(); iss_v = 1'b1; iss_rd = 5'd0;
    @(posedge clk); @(negedge clk);
    idle(); #1;
    checks++; if (busy_vec !== 32'h200) begin errors++; $display("FAIL issue_wins_r0_ignored: got %h expected 200", busy_vec); end
  endtask

  task automatic test_random();
    exp_t e, g;
    rst = 1'b1; idle(); m_reset(); #1;
    rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < RDN; p++) rn[p*AWL +: AWL] = rand_addr();
      for (int w = 0; w < WRN; w++) begin
        we[w] = ($urandom_range(0, 2) != 0);
        wn[w*AWL +: AWL] = rand_addr();
        wd[w*XL +: XL] = $urandom;
      end
      iss_v = ($urandom_range(0, 2) == 0);
      iss_rd = rand_addr();
      rst = ($urandom_range(0, 499) == 0);
      for (int p = 0; p < RDN; p++) begin
        e.rd[p*XL +: XL] = rst ? '0 : m_read(rn[p*AWL +: AWL]);
        e.rbusy[p] = rst ? 1'b0 : (m_busy[rn[p*AWL +: AWL]] & ~m_clr(rn[p*AWL +: AWL]));
      end
      e.busy = rst ? '0 : m_busy;
      exp_q.push_back(e);
      #1;
      g = exp_q.pop_front();
      checks++; if (rd !== g.rd) begin errors++; $display("FAIL rand_rd c=%0d: got %h expected %h", c, rd, g.rd); end
      checks++; if (rbusy !== g.rbusy) begin errors++; $display("FAIL rand_rbusy c=%0d: got %b expected %b", c, rbusy, g.rbusy); end
      checks++; if (busy_vec !== g.busy) begin errors++; $display("FAIL rand_busy c=%0d: got %h expected %h", c, busy_vec, g.busy); end
      @(posedge clk);
      m_update();
      @(negedge clk);
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_collision();
    test_scoreboard();
    @(negedge clk);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
